seq_divider: RTL and testbench

Iterative restoring divider, one quotient bit per clock, for the MIPS32 DIV/DIVU path. Each step is a magnitude compare of the partial remainder against the divisor, then a conditional subtract. Results feed the HI/LO register writeback: LO takes the quotient, HI takes the remainder. A start/busy/done handshake lets the pipeline stall on the datapath while a divide is running.

---
 rtl/div_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 30 +++
 rtl/div_step.sv | 34 +++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);
    localparam logic [WIDTH_DEFAULT-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the pipeline (master) and the divider (slave).
interface seq_divider_if import div_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    // Handshake: start is sampled only while busy=0 (IDLE or DONE); operands and
    // is_signed are captured on that edge. busy is high exactly while iterating,
    // done pulses for one cycle, and the results hold until the next accepted start.
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    state_t           dbg_state;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, dbg_state
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, dbg_state
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: compare the shifted partial remainder with the
// divisor magnitude and subtract when it is greater or equal.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic             ge,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    localparam int SLICES = WIDTH / 4;

    // ge_chain[i] means the low 4*i bits of rem_in are >= those of divisor.
    logic [SLICES:0] ge_chain;

    assign ge_chain[0] = 1'b1;

    for (genvar i = 0; i < SLICES; i++) begin : g_slice
        logic [3:0] a_s;
        logic [3:0] b_s;
        assign a_s = rem_in[4*i +: 4];
        assign b_s = divisor[4*i +: 4];
        assign ge_chain[i+1] = (a_s > b_s) | ((a_s == b_s) & ge_chain[i]);
    end

    assign ge    = rem_in[WIDTH] | ge_chain[SLICES];
    assign q_bit = ge;

    // The true difference is below the divisor, so WIDTH-bit modular arithmetic is exact.
    assign rem_out = ge ? (rem_in[WIDTH-1:0] - divisor) : rem_in[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, with
// sign correction applied on the way into DONE.
module seq_divider import div_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             is_signed_q, is_signed_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   step_in;
    logic             step_ge;
    logic             step_qbit;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] q_raw;

    // Negating the most-negative value yields itself, which read unsigned is 2^(WIDTH-1).
    assign dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    assign dvs_mag = dvs_neg ? -bus.divisor : bus.divisor;

    assign step_in = {rem_q, shift_q[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (step_in),
        .divisor (dvs_q),
        .ge      (step_ge),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        shift_d     = shift_q;
        dvs_d       = dvs_q;
        is_signed_d = is_signed_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        q_raw       = {shift_q[WIDTH-2:0], step_qbit};

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    is_signed_d = bus.is_signed;
                    sign_q_d    = dvd_neg ^ dvs_neg;
                    sign_r_d    = dvd_neg;
                    rem_d       = '0;
                    shift_d     = dvd_mag;
                    dvs_d       = dvs_mag;
                    cnt_d       = '0;
                    if (bus.divisor == '0) begin
                        // Result is architecturally defined here: no iteration needed.
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d   = step_rem;
                shift_d = q_raw;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    quotient_d  = (is_signed_q && sign_q_q) ? -q_raw : q_raw;
                    remainder_d = (is_signed_q && sign_r_q) ? -step_rem : step_rem;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            shift_q     <= '0;
            dvs_q       <= '0;
            is_signed_q <= 1'b0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            shift_q     <= shift_d;
            dvs_q       <= dvs_d;
            is_signed_q <= is_signed_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == CALC);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] exp_q[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer division (truncating toward zero for signed).
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic z);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after acceptance until done is seen, and cycles with busy high.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat, output int bcnt);
        drive_start(a, b, s);
        wait_done(lat, bcnt);
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.quotient !== '0) begin failures++; $display("FAIL reset_quotient: got %h expected 0", bus.quotient); end
        checks++; if (bus.remainder !== '0) begin failures++; $display("FAIL reset_remainder: got %h expected 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[8] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h12345678,
                                32'h12345678, 32'h80000000, 32'h80000000, 32'd7};
        logic [W-1:0] tb[8] = '{32'd7, 32'd2, 32'd2, 32'd0,
                                32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic         ts[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] eq[8] = '{32'd14, 32'hFFFFFFFD, 32'h7FFFFFFC, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFD};
        logic [W-1:0] er[8] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'h12345678,
                                32'h12345678, 32'd0, 32'h80000000, 32'd1};
        logic         ez[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] q, r;
        logic         z;
        int           lat, bcnt, exp_lat;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], q, r, z, lat, bcnt);
            exp_lat = ez[i] ? 0 : W;
            checks++; if (q !== eq[i]) begin failures++; $display("FAIL dir%0d_quotient: got %h expected %h", i, q, eq[i]); end
            checks++; if (r !== er[i]) begin failures++; $display("FAIL dir%0d_remainder: got %h expected %h", i, r, er[i]); end
            checks++; if (z !== ez[i]) begin failures++; $display("FAIL dir%0d_dbz: got %b expected %b", i, z, ez[i]); end
            checks++; if (lat !== exp_lat) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
            checks++; if (bcnt !== exp_lat) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bcnt, exp_lat); end
            @(posedge clk);
            #1;
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, bus.done); end
            checks++; if (bus.quotient !== eq[i]) begin failures++; $display("FAIL dir%0d_hold: got %h expected %h", i, bus.quotient, eq[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, mq, mr, xq, xr;
        logic         s, z, mz;
        int           lat, bcnt;
        for (int i = 0; i < 24; i++) begin
            a = $urandom();
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = '1;
                default: b = $urandom() >> $urandom_range(0, 28);
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, mq, mr, mz);
            exp_q.push_back(mq);
            exp_q.push_back(mr);
            run_op(a, b, s, q, r, z, lat, bcnt);
            xq = exp_q.pop_front();
            xr = exp_q.pop_front();
            checks++; if (q !== xq) begin failures++; $display("FAIL rand%0d_quotient: a=%h b=%h s=%b got %h expected %h", i, a, b, s, q, xq); end
            checks++; if (r !== xr) begin failures++; $display("FAIL rand%0d_remainder: a=%h b=%h s=%b got %h expected %h", i, a, b, s, r, xr); end
            checks++; if (z !== mz) begin failures++; $display("FAIL rand%0d_dbz: got %b expected %b", i, z, mz); end
            checks++; if (lat !== (mz ? 0 : W)) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, mz ? 0 : W); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        drive_start(32'd50, 32'd5, 1'b0);
        lat = 0;
        while (!bus.done && lat < 200) begin
            if (lat == 9) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd9;
                bus.divisor  = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        checks++; if (lat !== W) begin failures++; $display("FAIL ignore_latency: got %0d expected %0d", lat, W); end
        checks++; if (bus.quotient !== 32'd10) begin failures++; $display("FAIL ignore_quotient: got %h expected %h", bus.quotient, 32'd10); end
        checks++; if (bus.remainder !== 32'd0) begin failures++; $display("FAIL ignore_remainder: got %h expected 0", bus.remainder); end
        // Still inside the done cycle: this start must be accepted.
        bus.start     = 1'b1;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        bus.is_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bcnt);
        checks++; if (lat !== W) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", lat, W); end
        checks++; if (bus.quotient !== 32'd3) begin failures++; $display("FAIL b2b_quotient: got %h expected %h", bus.quotient, 32'd3); end
        checks++; if (bus.remainder !== 32'd0) begin failures++; $display("FAIL b2b_remainder: got %h expected 0", bus.remainder); end
    endtask

    task automatic test_abort();
        logic [W-1:0] q, r;
        logic         z;
        int           lat, bcnt, done_seen;
        drive_start(32'd1000, 32'd3, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.quotient !== '0) begin failures++; $display("FAIL abort_quotient: got %h expected 0", bus.quotient); end
        checks++; if (bus.remainder !== '0) begin failures++; $display("FAIL abort_remainder: got %h expected 0", bus.remainder); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", done_seen); end
        run_op(32'd1000, 32'd3, 1'b0, q, r, z, lat, bcnt);
        checks++; if (q !== 32'd333) begin failures++; $display("FAIL after_abort_quotient: got %h expected %h", q, 32'd333); end
        checks++; if (r !== 32'd1) begin failures++; $display("FAIL after_abort_remainder: got %h expected 1", r); end
        checks++; if (lat !== W) begin failures++; $display("FAIL after_abort_latency: got %0d expected %0d", lat, W); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus.quotient !== 32'd333) begin failures++; $display("FAIL idle_hold_quotient: got %h expected %h", bus.quotient, 32'd333); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL idle_done: got %b expected 0", bus.done); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
